// File: rtl/sig_check_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sig_check_pkg                                                              |
// | Shared types and helpers for the signature-check engine.                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sig_check_pkg;

    localparam int unsigned c_DATA_W    = 32;
    localparam int unsigned c_MAX_WORDS = 256;
    localparam int unsigned c_LEN_W     = $clog2(c_MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic                pass;
        logic                timed_out;
        logic [c_LEN_W-1:0]  err_count;
        logic [c_LEN_W-1:0]  first_err_idx;
        logic [c_DATA_W-1:0] first_err_got;
        logic [c_DATA_W-1:0] first_err_exp;
    } sig_result_t;

    function automatic logic [c_LEN_W-1:0] len_clamp(
        input logic [c_LEN_W-1:0] len,
        input logic [c_LEN_W-1:0] max_len
    );
        return (len > max_len) ? max_len : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sig_check_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sig_check_if                                                               |
// | Read ports toward data memory and the expected-signature ROM.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sig_check_if
    import sig_check_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = c_LEN_W
);
    logic              dm_rd_en;
    logic [ADDR_W-1:0] dm_rd_addr;
    logic [DATA_W-1:0] dm_rd_data;
    logic [LEN_W-1:0]  exp_rd_addr;
    logic [DATA_W-1:0] exp_rd_data;

    modport master (
        output dm_rd_en, dm_rd_addr, exp_rd_addr,
        input  dm_rd_data, exp_rd_data
    );

    modport slave (
        input  dm_rd_en, dm_rd_addr, exp_rd_addr,
        output dm_rd_data, exp_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/sig_cmp_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sig_cmp_stage                                                              |
// | Read-valid pipe, word comparator, saturating error count, first-error hold.|
// | Optional mismatch trace ports: SIG_CHECK_TRACE_EN.  Rev 1.0                |
// +----------------------------------------------------------------------------+
module sig_cmp_stage
    import sig_check_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int MAX_WORDS = c_MAX_WORDS,
    parameter int LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [LEN_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] dm_data,
    input  logic [DATA_W-1:0] exp_data,
    output logic [LEN_W-1:0]  err_count,
    output logic [LEN_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp
`ifdef SIG_CHECK_TRACE_EN
    ,
    output logic              mm_valid,
    output logic [LEN_W-1:0]  mm_idx,
    output logic [DATA_W-1:0] mm_got,
    output logic [DATA_W-1:0] mm_exp
`endif
);
    localparam logic [LEN_W-1:0] c_SAT = LEN_W'(MAX_WORDS);

    logic              r_vld;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  r_err_count;
    logic [LEN_W-1:0]  r_first_idx;
    logic [DATA_W-1:0] r_first_got;
    logic [DATA_W-1:0] r_first_exp;
    logic              w_mm;

    // Memory data lands one cycle after the strobe, so the pipe bit qualifies it.
    assign w_mm = r_vld && (dm_data != exp_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld       <= 1'b0;
            r_idx       <= '0;
            r_err_count <= '0;
            r_first_idx <= '0;
            r_first_got <= '0;
            r_first_exp <= '0;
        end else begin
            r_vld <= rd_en;
            r_idx <= rd_idx;
            if (clr) begin
                r_err_count <= '0;
                r_first_idx <= '0;
                r_first_got <= '0;
                r_first_exp <= '0;
            end else if (w_mm) begin
                if (r_err_count == '0) begin
                    r_first_idx <= r_idx;
                    r_first_got <= dm_data;
                    r_first_exp <= exp_data;
                end
                if (r_err_count != c_SAT) begin
                    r_err_count <= r_err_count + LEN_W'(1);
                end
            end
        end
    end

    assign err_count     = r_err_count;
    assign first_err_idx = r_first_idx;
    assign first_err_got = r_first_got;
    assign first_err_exp = r_first_exp;

`ifdef SIG_CHECK_TRACE_EN
    assign mm_valid = w_mm;
    assign mm_idx   = w_mm ? r_idx    : '0;
    assign mm_got   = w_mm ? dm_data  : '0;
    assign mm_exp   = w_mm ? exp_data : '0;
`endif

endmodule
`default_nettype wire

// File: rtl/sig_check_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sig_check_engine                                                           |
// | Waits for halt/timeout, then streams and compares the signature region.    |
// | Optional per-mismatch trace ports: SIG_CHECK_TRACE_EN.  Rev 1.0            |
// +----------------------------------------------------------------------------+
module sig_check_engine
    import sig_check_pkg::*;
#(
    parameter  int DATA_W    = c_DATA_W,
    parameter  int ADDR_W    = 32,
    parameter  int SIG_BASE  = 'h40,
    parameter  int MAX_WORDS = c_MAX_WORDS,
    parameter  int TIMEOUT   = 100,
    localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic [LEN_W-1:0]  sig_len,
    sig_check_if.master       mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [LEN_W-1:0]  err_count,
    output logic [LEN_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp
`ifdef SIG_CHECK_TRACE_EN
    ,
    output logic              mm_valid,
    output logic [LEN_W-1:0]  mm_idx,
    output logic [DATA_W-1:0] mm_got,
    output logic [DATA_W-1:0] mm_exp
`endif
);
    localparam int               CYC_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CYC_W-1:0] c_TO_LAST   = CYC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [LEN_W-1:0] c_MAX_LEN   = LEN_W'(MAX_WORDS);

    state_e            r_state;
    state_e            w_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [CYC_W-1:0]  r_cyc;
    logic              r_to;
    logic              w_start;
    logic              w_to;
    logic              w_exit;
    logic              w_last;
    logic              w_rd_en;
    logic [LEN_W-1:0]  w_err_count;
    logic [LEN_W-1:0]  w_first_idx;
    logic [DATA_W-1:0] w_first_got;
    logic [DATA_W-1:0] w_first_exp;
    sig_result_t       w_res;

    assign w_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_to    = (TIMEOUT != 0) && (r_cyc == c_TO_LAST);
    assign w_exit  = halt || w_to;
    assign w_last  = (r_idx == r_len - LEN_W'(1));
    assign w_rd_en = (r_state == S_READ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_nxt = S_RUN;
            S_RUN:   if (w_exit) w_nxt = (r_len == '0) ? S_DONE : S_READ;
            S_READ:  if (w_last) w_nxt = S_DRAIN;
            S_DRAIN: w_nxt = S_DONE;
            S_DONE:  if (start) w_nxt = S_RUN;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Halt takes priority over a coincident timeout, so timed_out is set only for a pure timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_idx <= '0;
            r_cyc <= '0;
            r_to  <= 1'b0;
        end else if (w_start) begin
            r_len <= len_clamp(sig_len, c_MAX_LEN);
            r_idx <= '0;
            r_cyc <= '0;
            r_to  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_cyc <= r_cyc + CYC_W'(1);
            if (w_exit) r_to <= !halt;
        end else if (r_state == S_READ) begin
            r_idx <= r_idx + LEN_W'(1);
        end
    end

    assign mem.dm_rd_en    = w_rd_en;
    assign mem.dm_rd_addr  = w_rd_en ? (ADDR_W'(SIG_BASE) + ADDR_W'(r_idx)) : '0;
    assign mem.exp_rd_addr = w_rd_en ? r_idx : '0;

    sig_cmp_stage #(
        .DATA_W    (DATA_W),
        .MAX_WORDS (MAX_WORDS),
        .LEN_W     (LEN_W)
    ) u_cmp (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (w_start),
        .rd_en         (w_rd_en),
        .rd_idx        (r_idx),
        .dm_data       (mem.dm_rd_data),
        .exp_data      (mem.exp_rd_data),
        .err_count     (w_err_count),
        .first_err_idx (w_first_idx),
        .first_err_got (w_first_got),
        .first_err_exp (w_first_exp)
`ifdef SIG_CHECK_TRACE_EN
        ,
        .mm_valid      (mm_valid),
        .mm_idx        (mm_idx),
        .mm_got        (mm_got),
        .mm_exp        (mm_exp)
`endif
    );

    always_comb begin
        w_res               = '0;
        w_res.pass          = (r_state == S_DONE) && (w_err_count == '0);
        w_res.timed_out     = r_to;
        w_res.err_count     = w_err_count;
        w_res.first_err_idx = w_first_idx;
        w_res.first_err_got = w_first_got;
        w_res.first_err_exp = w_first_exp;
    end

    assign busy          = (r_state == S_RUN) || (r_state == S_READ) || (r_state == S_DRAIN);
    assign done          = (r_state == S_DONE);
    assign pass          = w_res.pass;
    assign timed_out     = w_res.timed_out;
    assign err_count     = w_res.err_count;
    assign first_err_idx = w_res.first_err_idx;
    assign first_err_got = w_res.first_err_got;
    assign first_err_exp = w_res.first_err_exp;

endmodule
`default_nettype wire

// File: tb/tb_sig_check_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sig_check_engine                                                        |
// | Directed bench for sig_check_engine with a DM/ROM model and result queue.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sig_check_engine;
    import sig_check_pkg::*;

    localparam int c_BASE = 'h40;
    localparam int c_MAXW = 256;
    localparam int c_TO   = 100;

    typedef struct {
        int          err;
        int          fidx;
        logic [31:0] fgot;
        logic [31:0] fexp;
        bit          to;
        int          lat;
        int          ex;
        int          nrd;
    } exp_t;

    logic                clk     = 1'b0;
    logic                rst_n   = 1'b0;
    logic                start   = 1'b0;
    logic                halt    = 1'b0;
    logic [c_LEN_W-1:0]  sig_len = '0;
    logic                busy, done, pass, timed_out;
    logic [c_LEN_W-1:0]  err_count, first_err_idx;
    logic [31:0]         first_err_got, first_err_exp;

    logic [31:0] dm_mem  [0:511];
    logic [31:0] exp_rom [0:255];
    exp_t        sbq [$];
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          burst  = 0;
    int          mm_cnt = 0;

    sig_check_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(c_LEN_W)) mem_if ();

`ifdef SIG_CHECK_TRACE_EN
    logic               mm_valid;
    logic [c_LEN_W-1:0] mm_idx;
    logic [31:0]        mm_got, mm_exp;
`endif

    sig_check_engine #(
        .DATA_W(32), .ADDR_W(32), .SIG_BASE(c_BASE), .MAX_WORDS(c_MAXW), .TIMEOUT(c_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .sig_len(sig_len),
        .mem(mem_if),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_got(first_err_got), .first_err_exp(first_err_exp)
`ifdef SIG_CHECK_TRACE_EN
        , .mm_valid(mm_valid), .mm_idx(mm_idx), .mm_got(mm_got), .mm_exp(mm_exp)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_if.dm_rd_data  <= '0;
            mem_if.exp_rd_data <= '0;
        end else if (mem_if.dm_rd_en) begin
            mem_if.dm_rd_data  <= dm_mem[mem_if.dm_rd_addr[8:0]];
            mem_if.exp_rd_data <= exp_rom[mem_if.exp_rd_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reads must be one contiguous burst from index 0.
    always @(negedge clk) begin
        if (mem_if.dm_rd_en) begin
            chk("rd_addr", mem_if.dm_rd_addr, 32'(c_BASE + burst));
            chk("rom_addr", 32'(mem_if.exp_rd_addr), 32'(burst));
            burst++;
            rd_cnt++;
        end else begin
            burst = 0;
        end
    end

`ifdef SIG_CHECK_TRACE_EN
    always @(negedge clk) begin
        if (mm_valid) begin
            chk("mm_got", mm_got, dm_mem[c_BASE + int'(mm_idx)]);
            chk("mm_exp", mm_exp, exp_rom[mm_idx[7:0]]);
            mm_cnt++;
        end
    end
`endif

    task automatic fill_match();
        for (int i = 0; i < 256; i++) begin
            exp_rom[i]          = 32'hC0DE_0000 + 32'(i * 7);
            dm_mem[c_BASE + i]  = exp_rom[i];
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ":busy"}, 32'(busy), 32'd0);
        chk({tag, ":done"}, 32'(done), 32'd0);
        chk({tag, ":pass"}, 32'(pass), 32'd0);
        chk({tag, ":to"}, 32'(timed_out), 32'd0);
        chk({tag, ":err"}, 32'(err_count), 32'd0);
        chk({tag, ":fidx"}, 32'(first_err_idx), 32'd0);
        chk({tag, ":fgot"}, first_err_got, 32'd0);
        chk({tag, ":fexp"}, first_err_exp, 32'd0);
        chk({tag, ":rd_en"}, 32'(mem_if.dm_rd_en), 32'd0);
        chk({tag, ":rd_addr"}, mem_if.dm_rd_addr, 32'd0);
        chk({tag, ":rom_addr"}, 32'(mem_if.exp_rd_addr), 32'd0);
    endtask

    // halt_cyc < 0: never halt. Exit cycle is counted from RUN cycle 0.
    task automatic do_run(input string name, input int len_in, input int halt_cyc, input bit busy_start);
        exp_t e;
        int   l, n, lat, rd0, mm0, tot;
        l      = (len_in > c_MAXW) ? c_MAXW : len_in;
        e.err  = 0; e.fidx = 0; e.fgot = '0; e.fexp = '0; tot = 0;
        for (int i = 0; i < l; i++) begin
            if (dm_mem[c_BASE + i] !== exp_rom[i]) begin
                if (e.err == 0) begin
                    e.fidx = i;
                    e.fgot = dm_mem[c_BASE + i];
                    e.fexp = exp_rom[i];
                end
                e.err++;
            end
        end
        tot   = e.err;
        e.to  = (halt_cyc < 0) || (halt_cyc >= c_TO);
        e.ex  = e.to ? c_TO - 1 : halt_cyc;
        e.lat = (l == 0) ? 1 : l + 2;
        e.nrd = l;
        sbq.push_back(e);

        rd0 = rd_cnt;
        mm0 = mm_cnt;
        sig_len = c_LEN_W'(len_in);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({name, ":busy0"}, 32'(busy), 32'd1);
        chk({name, ":done0"}, 32'(done), 32'd0);
        chk({name, ":err0"}, 32'(err_count), 32'd0);

        n = 0;
        while (!mem_if.dm_rd_en && !done && n < 400) begin
            halt  = (n == halt_cyc);
            start = busy_start && (n == 2);
            @(negedge clk);
            n++;
        end
        halt  = 1'b0;
        start = 1'b0;
        chk({name, ":exit_cyc"}, 32'(n), 32'(e.ex + 1));

        lat = 1;
        while (!done && lat < 600) begin
            start = busy_start && (lat == 2);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;

        e = sbq.pop_front();
        chk({name, ":latency"}, 32'(lat), 32'(e.lat));
        chk({name, ":done"}, 32'(done), 32'd1);
        chk({name, ":busy"}, 32'(busy), 32'd0);
        chk({name, ":pass"}, 32'(pass), 32'(e.err == 0));
        chk({name, ":timed_out"}, 32'(timed_out), 32'(e.to));
        chk({name, ":err_count"}, 32'(err_count), 32'(e.err));
        chk({name, ":first_idx"}, 32'(first_err_idx), 32'(e.fidx));
        chk({name, ":first_got"}, first_err_got, e.fgot);
        chk({name, ":first_exp"}, first_err_exp, e.fexp);
        chk({name, ":reads"}, 32'(rd_cnt - rd0), 32'(e.nrd));
`ifdef SIG_CHECK_TRACE_EN
        chk({name, ":mm_pulses"}, 32'(mm_cnt - mm0), 32'(tot));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fill_match();
        for (int i = 0; i < c_BASE; i++) dm_mem[i] = '0;
        for (int i = c_BASE + 256; i < 512; i++) dm_mem[i] = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: all match, halt at RUN cycle 20
        do_run("t1", 4, 20, 1'b0);

        // 2: mismatches at idx 1 and 3
        fill_match();
        dm_mem[c_BASE + 1] = 32'h5;
        exp_rom[1]         = 32'h6;
        dm_mem[c_BASE + 3] = 32'h1234;
        do_run("t2", 4, 10, 1'b0);

        // 3: no halt, forced check after TIMEOUT cycles
        fill_match();
        do_run("t3", 4, -1, 1'b0);

        // 4: halt coincident with timeout; then zero-length signature
        do_run("t4a", 4, c_TO - 1, 1'b0);
        do_run("t4b", 0, 5, 1'b0);

        // 5: reset in the middle of READ at idx 2
        fill_match();
        dm_mem[c_BASE] = 32'hDEAD_0000;
        sig_len = 4;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        halt = 1'b1;
        @(negedge clk) halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5:addr_idx2", mem_if.dm_rd_addr, 32'(c_BASE + 2));
        chk("t5:err_pre", 32'(err_count), 32'd1);
        chk("t5:fgot_pre", first_err_got, 32'hDEAD_0000);
        rst_n = 1'b0;
        #1;
        check_zero("t5_rst");
        @(negedge clk);
        check_zero("t5_hold");
        rst_n = 1'b1;
        @(negedge clk);
        fill_match();
        do_run("t5", 4, 20, 1'b0);

        // 6: start while busy is ignored; oversize length clamps to MAX_WORDS
        fill_match();
        dm_mem[c_BASE + 2] = dm_mem[c_BASE + 2] ^ 32'h1;
        do_run("t6a", 4, 8, 1'b1);
        fill_match();
        dm_mem[c_BASE + 0]   = 32'h0;
        dm_mem[c_BASE + 128] = 32'h2;
        dm_mem[c_BASE + 255] = 32'h1;
        do_run("t6b", c_MAXW + 5, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
